axi_master_arbiter: RTL and testbench
=====================================

Name: axi_master_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the AXI4-lite master's master-side interface (M_access / ready_M / read_data_M / read_data_valid_M / resp_M).
- Requester 0 is the instruction-fetch path; requester 1 is the data load/store path.
- The block selects one requester and holds its command stable while the master runs the transaction. It then returns the read data and response to that requester as a one-cycle completion pulse.

Parameters:
- ADDR_WIDTH, 32, address width of requesters and master.
- DATA_WIDTH, 32, data width of requesters and master.
- PRIO_MODE, 0. 0 = round-robin; 1 = fixed priority, requester 1 wins.

Ports:
- ACLK  in  1  clock, shared with the AXI master.
- ARESETn  in  1  asynchronous active-low reset.
- rN_access  in  1  request from requester N (N=0,1). Held high with a stable command until rN_done.
- rN_rd0_wr1  in  1  command for requester N: 0 = read, 1 = write.
- rN_addr  in  ADDR_WIDTH  address from requester N.
- rN_wdata  in  DATA_WIDTH  write data from requester N.
- rN_strobe  in  4  write byte strobe from requester N.
- rN_done  out  1  one-cycle completion pulse to requester N.
- rN_rdata  out  DATA_WIDTH  read data; valid only while rN_done=1 on a read, else 0.
- rN_resp  out  2  AXI response; valid only while rN_done=1, else 0.
- M_access  out  1  access strobe to the master.
- M_rd0_wr1  out  1  latched command.
- M_addr  out  ADDR_WIDTH  latched address.
- M_write_data  out  DATA_WIDTH  latched write data.
- M_write_strobe  out  4  latched strobe.
- ready_M  in  1  master idle.
- read_data_M  in  DATA_WIDTH  master read data.
- read_data_valid_M  in  1  master read-data valid.
- resp_M  in  2  master response.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state = IDLE; last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If ready_M=1 and any rN_access=1: choose a winner, latch its command into the M_* registers, record gnt_id, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - M_access=1 for exactly this one cycle; go to WAIT unconditionally.
  - The master samples M_access while it is idle, then leaves idle on the next edge.
- WAIT:
  - M_access=0.
  - Every cycle with ready_M=0: capture resp_M into resp_q.
  - When read_data_valid_M=1: capture read_data_M into rdata_q.
  - When ready_M=1: go to RESP. This cannot occur in the first WAIT cycle, because the master is then busy.
- RESP:
  - Drive r{gnt_id}_done=1 with rdata_q (0 for writes) and resp_q for one cycle.
  - Update last_grant=gnt_id; go to IDLE.
- Winner selection:
  - PRIO_MODE=0: a lone requester wins. If both request, the requester not equal to last_grant wins.
  - PRIO_MODE=1: requester 1 wins whenever it requests.
- M_addr, M_write_data and M_write_strobe hold their latched values from ISSUE through RESP. They return to 0 in IDLE.
- A requester must drop rN_access in the cycle after rN_done; otherwise a new transaction starts.
- A request already held in RESP is arbitrated in the following IDLE cycle. Minimum spacing between back-to-back grants is therefore one idle cycle.
- Latency: grant cycle, ISSUE, master transaction (at least 3 cycles), then RESP.
- Only the granted requester's rN_done may pulse. Both requesters never receive rN_done in the same cycle.
- Reset mid-operation: the FSM returns to IDLE and all pulses and latches clear. No rN_done is produced for the aborted transaction.

Test Plan:
- Read, r0 only: r0_addr=0x100, slave returns 0xDEADBEEF with OKAY → M_access pulses once with M_addr=0x100 and M_rd0_wr1=0; r0_done pulses once with r0_rdata=0xDEADBEEF and r0_resp=0; r1_done stays 0.
- Write, r1 only: r1_addr=0x200, r1_wdata=0x12345678, r1_strobe=0xF, slave BRESP=2'b10 → M_write_data=0x12345678 and M_write_strobe=0xF held through WAIT; r1_done pulses with r1_resp=2'b10 and r1_rdata=0.
- Contention, PRIO_MODE=0, r0 and r1 held together for 4 transactions each → grant order 0,1,0,1,…; each requester gets exactly 4 rN_done pulses.
- Contention, PRIO_MODE=1, r1 requests continuously for 3 transactions while r0 is held → three r1 grants, then r0 is served.
- ready_M low at request time (master still busy) → stay in IDLE, M_access=0; grant only after ready_M=1.
- Reset: ARESETn asserted during WAIT of a read → all outputs 0 immediately; no rN_done pulse; a new r0 read after release completes normally.

Source files
------------

// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter
//   Two-requester arbiter/sequencer in front of the AXI4-lite master's
//   master-side interface. Requester 0 is instruction fetch, requester 1 is
//   data load/store. One requester is selected, its command is latched and
//   held while the master runs, then read data and response are returned to
//   that requester as a one-cycle completion pulse.
//
// Ports
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   rN_access/rd0_wr1/addr/
//   wdata/strobe (N=0,1)     requester command, held until rN_done
//   rN_done/rdata/resp       one-cycle completion with read data and response
//   M_access/rd0_wr1/addr/
//   write_data/write_strobe  latched command and access strobe to the master
//   ready_M, read_data_M,
//   read_data_valid_M,resp_M master status and return data
//   busy                     high whenever the sequencer is not idle
//
// Parameters
//   PRIO_MODE  0 = round-robin, 1 = fixed priority with requester 1 winning
//
// state  | meaning
// IDLE   | waiting for a request while the master is ready; grants on entry to ISSUE
// ISSUE  | M_access high for one cycle so the idle master samples the command
// WAIT   | master busy; response and read data captured until ready_M returns
// RESP   | completion pulse to the granted requester, then back to IDLE

module axi_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PRIO_MODE  = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  r0_access,
  input  logic                  r0_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic [3:0]            r0_strobe,
  output logic                  r0_done,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic [1:0]            r0_resp,
  input  logic                  r1_access,
  input  logic                  r1_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic [3:0]            r1_strobe,
  output logic                  r1_done,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [1:0]            r1_resp,
  output logic                  M_access,
  output logic                  M_rd0_wr1,
  output logic [ADDR_WIDTH-1:0] M_addr,
  output logic [DATA_WIDTH-1:0] M_write_data,
  output logic [3:0]            M_write_strobe,
  input  logic                  ready_M,
  input  logic [DATA_WIDTH-1:0] read_data_M,
  input  logic                  read_data_valid_M,
  input  logic [1:0]            resp_M,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                state_q;
  logic                  last_grant_q;
  logic                  gnt_q;
  logic                  m_access_q;
  logic                  m_wr_q;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic [DATA_WIDTH-1:0] m_wdata_q;
  logic [3:0]            m_strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic [1:0]            done_q;
  logic [DATA_WIDTH-1:0] r0_rdata_q;
  logic [DATA_WIDTH-1:0] r1_rdata_q;
  logic [1:0]            r0_resp_q;
  logic [1:0]            r1_resp_q;
  logic                  busy_q;

  logic                  any_req_d;
  logic                  win_d;
  logic                  sel_wr_d;
  logic [ADDR_WIDTH-1:0] sel_addr_d;
  logic [DATA_WIDTH-1:0] sel_wdata_d;
  logic [3:0]            sel_strb_d;
  logic [DATA_WIDTH-1:0] rdata_fin_d;

  always_comb begin
    any_req_d = r0_access | r1_access;
    // Round-robin tie goes to the requester that was not served last.
    if (PRIO_MODE == 1)
      win_d = r1_access;
    else if (r0_access && r1_access)
      win_d = ~last_grant_q;
    else
      win_d = r1_access;

    sel_wr_d    = win_d ? r1_rd0_wr1 : r0_rd0_wr1;
    sel_addr_d  = win_d ? r1_addr    : r0_addr;
    sel_wdata_d = win_d ? r1_wdata   : r0_wdata;
    sel_strb_d  = win_d ? r1_strobe  : r0_strobe;

    // Read data arriving in the same cycle as ready_M is forwarded directly.
    if (m_wr_q)
      rdata_fin_d = '0;
    else if (read_data_valid_M)
      rdata_fin_d = read_data_M;
    else
      rdata_fin_d = rdata_q;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      m_access_q   <= 1'b0;
      m_wr_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_strb_q     <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
      done_q       <= '0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
      r0_resp_q    <= '0;
      r1_resp_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ready_M && any_req_d) begin
            state_q    <= S_ISSUE;
            gnt_q      <= win_d;
            m_access_q <= 1'b1;
            busy_q     <= 1'b1;
            m_wr_q     <= sel_wr_d;
            m_addr_q   <= sel_addr_d;
            m_wdata_q  <= sel_wdata_d;
            m_strb_q   <= sel_strb_d;
            rdata_q    <= '0;
            resp_q     <= '0;
          end
        end
        S_ISSUE: begin
          state_q    <= S_WAIT;
          m_access_q <= 1'b0;
        end
        S_WAIT: begin
          // The last response seen while the master is busy is the final one.
          if (!ready_M)
            resp_q <= resp_M;
          if (read_data_valid_M)
            rdata_q <= read_data_M;
          if (ready_M) begin
            state_q <= S_RESP;
            if (gnt_q) begin
              done_q     <= 2'b10;
              r1_rdata_q <= rdata_fin_d;
              r1_resp_q  <= resp_q;
            end else begin
              done_q     <= 2'b01;
              r0_rdata_q <= rdata_fin_d;
              r0_resp_q  <= resp_q;
            end
          end
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          last_grant_q <= gnt_q;
          busy_q       <= 1'b0;
          done_q       <= '0;
          r0_rdata_q   <= '0;
          r1_rdata_q   <= '0;
          r0_resp_q    <= '0;
          r1_resp_q    <= '0;
          m_wr_q       <= 1'b0;
          m_addr_q     <= '0;
          m_wdata_q    <= '0;
          m_strb_q     <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign r0_done        = done_q[0];
  assign r1_done        = done_q[1];
  assign r0_rdata       = r0_rdata_q;
  assign r1_rdata       = r1_rdata_q;
  assign r0_resp        = r0_resp_q;
  assign r1_resp        = r1_resp_q;
  assign M_access       = m_access_q;
  assign M_rd0_wr1      = m_wr_q;
  assign M_addr         = m_addr_q;
  assign M_write_data   = m_wdata_q;
  assign M_write_strobe = m_strb_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: one environment per arbitration mode, each
// with two requester drivers, an idle/busy master model, a reference
// arbiter and a completion scoreboard.
`timescale 1ns/1ps
module tb_axi_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int REQ_LIMIT = 2000;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          gap;
  } cmd_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic cmd_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int gap);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata; c.strb = strb; c.gap = gap;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd(input int maxgap);
    cmd_t c;
    c.wr    = 1'($urandom);
    c.addr  = $urandom & 32'hFFFF_FFFC;
    c.wdata = $urandom;
    c.strb  = 4'($urandom);
    c.gap   = $urandom_range(0, maxgap);
    return c;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : env
    logic        rst_n;
    logic        r_acc [2];
    logic        r_wr [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_strb [2];
    logic        r0_done, r1_done;
    logic [31:0] r0_rdata, r1_rdata;
    logic [1:0]  r0_resp, r1_resp;
    logic        M_access, M_rd0_wr1;
    logic [31:0] M_addr, M_write_data;
    logic [3:0]  M_write_strobe;
    logic        ready_M, read_data_valid_M, busy;
    logic [31:0] read_data_M;
    logic [1:0]  resp_M;

    axi_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRIO_MODE(g)) dut (
      .ACLK(ACLK), .ARESETn(rst_n),
      .r0_access(r_acc[0]), .r0_rd0_wr1(r_wr[0]), .r0_addr(r_addr[0]), .r0_wdata(r_wdata[0]),
      .r0_strobe(r_strb[0]), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_resp(r0_resp),
      .r1_access(r_acc[1]), .r1_rd0_wr1(r_wr[1]), .r1_addr(r_addr[1]), .r1_wdata(r_wdata[1]),
      .r1_strobe(r_strb[1]), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_resp(r1_resp),
      .M_access(M_access), .M_rd0_wr1(M_rd0_wr1), .M_addr(M_addr), .M_write_data(M_write_data),
      .M_write_strobe(M_write_strobe), .ready_M(ready_M), .read_data_M(read_data_M),
      .read_data_valid_M(read_data_valid_M), .resp_M(resp_M), .busy(busy)
    );

    cmd_t        cmdq0[$];
    cmd_t        cmdq1[$];
    exp_t        expq[$];
    int          done_log[$];
    int          done_cnt [2];
    int          macc_cnt;
    bit          fin;
    bit          m_start, m_hold, m_rd;
    int          m_len, m_cnt;
    logic [31:0] m_data;
    logic [1:0]  m_resp;
    bit          f_en;
    logic [31:0] f_data;
    logic [1:0]  f_resp;
    int          model_last;
    logic        p_acc0, p_acc1, p_ready, p_busy;
    cmd_t        cur;

    function automatic int qsize(input int n);
      return (n == 0) ? cmdq0.size() : cmdq1.size();
    endfunction

    function automatic cmd_t qpop(input int n);
      cmd_t c;
      if (n == 0) c = cmdq0.pop_front();
      else        c = cmdq1.pop_front();
      return c;
    endfunction

    // Requester: holds each command until its done pulse; gap 0 keeps
    // access high with the next command for a back-to-back request.
    task automatic req_run(input int n);
      cmd_t c;
      int   waitc;
      @(posedge ACLK); #1;
      while (qsize(n) > 0) begin
        c = qpop(n);
        if (c.gap > 0) begin
          r_acc[n] = 1'b0;
          repeat (c.gap) begin @(posedge ACLK); #1; end
        end
        r_acc[n] = 1'b1; r_wr[n] = c.wr; r_addr[n] = c.addr;
        r_wdata[n] = c.wdata; r_strb[n] = c.strb;
        waitc = 0;
        do begin
          @(negedge ACLK);
          waitc++;
        end while (!((n == 1) ? r1_done : r0_done) && waitc < REQ_LIMIT);
        chk("req_complete", waitc < REQ_LIMIT, 1'b1);
        @(posedge ACLK); #1;
      end
      r_acc[n] = 1'b0;
    endtask

    // Master model: idle while ready_M=1; after sampling M_access it is busy
    // for m_len cycles, with garbage response except in the final busy cycle.
    initial begin
      ready_M = 1'b1; read_data_valid_M = 1'b0; read_data_M = '0; resp_M = '0; m_cnt = 0;
      forever begin
        @(posedge ACLK); #1;
        if (!rst_n) begin
          ready_M = 1'b1; read_data_valid_M = 1'b0; m_cnt = 0;
        end else if (m_cnt > 0) begin
          m_cnt--;
          read_data_valid_M = 1'b0; read_data_M = $urandom; resp_M = 2'($urandom);
          if (m_cnt == 0) ready_M = 1'b1;
          else if (m_cnt == 1) begin
            resp_M = m_resp;
            if (m_rd) begin read_data_valid_M = 1'b1; read_data_M = m_data; end
          end
        end else if (m_start) begin
          m_start = 1'b0; ready_M = 1'b0; m_cnt = m_len;
          resp_M = 2'($urandom); read_data_M = $urandom;
        end else begin
          ready_M = !m_hold;
        end
      end
    end

    // Reference arbiter + scoreboard monitor.
    initial begin
      model_last = 1; macc_cnt = 0; done_cnt[0] = 0; done_cnt[1] = 0;
      p_acc0 = 1'b0; p_acc1 = 1'b0; p_ready = 1'b0; p_busy = 1'b0;
      forever begin
        @(negedge ACLK);
        if (!rst_n) begin
          expq.delete(); model_last = 1; m_start = 1'b0;
          p_acc0 = 1'b0; p_acc1 = 1'b0; p_ready = 1'b0; p_busy = 1'b0;
          continue;
        end
        if (M_access) begin
          int   w;
          exp_t e;
          macc_cnt++;
          chk("issue_from_idle", {p_busy, p_ready, p_acc0 | p_acc1}, 3'b011);
          if (g == 1)                w = p_acc1 ? 1 : 0;
          else if (p_acc0 && p_acc1) w = 1 - model_last;
          else                       w = p_acc1 ? 1 : 0;
          model_last = w;
          cur.wr = r_wr[w]; cur.addr = r_addr[w]; cur.wdata = r_wdata[w]; cur.strb = r_strb[w];
          chk("grant_cmd", {M_rd0_wr1, M_write_strobe, M_addr}, {cur.wr, cur.strb, cur.addr});
          chk("grant_wdata", M_write_data, cur.wdata);
          chk("busy_issue", busy, 1'b1);
          m_len  = $urandom_range(2, 5);
          m_rd   = !cur.wr;
          m_data = f_en ? f_data : $urandom;
          m_resp = f_en ? f_resp : 2'($urandom);
          f_en   = 1'b0;
          e.id = w; e.rdata = cur.wr ? 32'd0 : m_data; e.resp = m_resp;
          expq.push_back(e);
          m_start = 1'b1;
        end else if (busy) begin
          chk("hold_cmd", {M_rd0_wr1, M_write_strobe, M_addr}, {cur.wr, cur.strb, cur.addr});
          chk("hold_wdata", M_write_data, cur.wdata);
        end else begin
          chk("idle_zero", {M_rd0_wr1, M_write_strobe, (M_addr | M_write_data)}, '0);
        end
        if (r0_done || r1_done) begin
          exp_t e;
          int   id;
          id = r1_done ? 1 : 0;
          chk("single_done", {r0_done, r1_done} == 2'b11, 1'b0);
          chk("done_busy", busy, 1'b1);
          chk("done_expected", expq.size() > 0, 1'b1);
          done_cnt[id]++;
          done_log.push_back(id);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("done_id", id, e.id);
            chk("done_rdata", (id == 1) ? r1_rdata : r0_rdata, e.rdata);
            chk("done_resp", (id == 1) ? r1_resp : r0_resp, e.resp);
          end
        end
        chk("r0_quiet", r0_done ? 34'd0 : {r0_resp, r0_rdata}, '0);
        chk("r1_quiet", r1_done ? 34'd0 : {r1_resp, r1_rdata}, '0);
        p_acc0 = r_acc[0]; p_acc1 = r_acc[1]; p_ready = ready_M; p_busy = busy;
      end
    end

    // Directed phases followed by random traffic.
    initial begin
      int sav0, sav1, sav, waitc;
      int eo[$];
      rst_n = 1'b0; fin = 1'b0; m_hold = 1'b0; f_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_acc[i] = 1'b0; r_wr[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_strb[i] = '0;
      end
      repeat (3) @(posedge ACLK);
      #2;
      chk("rst_ctrl", {M_access, busy, r0_done, r1_done, M_rd0_wr1, M_write_strobe}, '0);
      chk("rst_m_data", {M_addr, M_write_data}, '0);
      chk("rst_rdata", {r0_rdata, r1_rdata}, '0);
      chk("rst_resp", {r0_resp, r1_resp}, '0);
      @(negedge ACLK); rst_n = 1'b1;
      repeat (2) @(posedge ACLK);

      // Read from r0 only.
      f_en = 1'b1; f_data = 32'hDEADBEEF; f_resp = 2'b00;
      cmdq0.push_back(mk(1'b0, 32'h100, 32'h0, 4'h0, 0));
      req_run(0);
      chk("rd_r0_done_cnt", done_cnt[0], 1);
      chk("rd_r1_done_cnt", done_cnt[1], 0);
      chk("rd_access_cnt", macc_cnt, 1);

      // Write from r1 only with SLVERR.
      f_en = 1'b1; f_data = $urandom; f_resp = 2'b10;
      cmdq1.push_back(mk(1'b1, 32'h200, 32'h12345678, 4'hF, 0));
      req_run(1);
      chk("wr_r1_done_cnt", done_cnt[1], 1);
      chk("wr_access_cnt", macc_cnt, 2);

      // Contention: both requesters start together and re-request back to back.
      done_log.delete();
      if (g == 0) begin
        for (int i = 0; i < 4; i++) begin cmdq0.push_back(rnd_cmd(0)); cmdq1.push_back(rnd_cmd(0)); end
        eo = '{0, 1, 0, 1, 0, 1, 0, 1};
      end else begin
        for (int i = 0; i < 3; i++) cmdq1.push_back(rnd_cmd(0));
        cmdq0.push_back(rnd_cmd(0));
        eo = '{1, 1, 1, 0};
      end
      fork
        req_run(0);
        req_run(1);
      join
      chk("order_len", done_log.size(), eo.size());
      for (int i = 0; i < eo.size() && i < done_log.size(); i++)
        chk("grant_order", done_log[i], eo[i]);

      // Master busy at request time: no grant until ready_M returns.
      m_hold = 1'b1;
      repeat (2) @(posedge ACLK);
      sav = macc_cnt;
      cmdq0.push_back(mk(1'b0, 32'h180, 32'h0, 4'h0, 0));
      fork
        req_run(0);
        begin
          repeat (6) @(negedge ACLK);
          chk("hold_no_issue", macc_cnt, sav);
          chk("hold_idle", busy, 1'b0);
          m_hold = 1'b0;
        end
      join
      chk("hold_served", macc_cnt, sav + 1);

      // Random traffic from both requesters.
      sav0 = done_cnt[0]; sav1 = done_cnt[1];
      for (int i = 0; i < 20; i++) begin cmdq0.push_back(rnd_cmd(3)); cmdq1.push_back(rnd_cmd(3)); end
      fork
        req_run(0);
        req_run(1);
      join
      chk("rand_r0_cnt", done_cnt[0], sav0 + 20);
      chk("rand_r1_cnt", done_cnt[1], sav1 + 20);

      // Reset during WAIT of a read, then a clean read.
      @(posedge ACLK); #1;
      r_acc[0] = 1'b1; r_wr[0] = 1'b0; r_addr[0] = 32'h300; r_wdata[0] = 32'hA5A5A5A5; r_strb[0] = 4'h3;
      waitc = 0;
      while (!M_access && waitc < 20) begin @(negedge ACLK); waitc++; end
      chk("abort_issue", M_access, 1'b1);
      @(posedge ACLK); #3;
      rst_n = 1'b0;
      #1;
      chk("abort_ctrl", {M_access, busy, M_rd0_wr1, M_write_strobe, r0_done, r1_done}, '0);
      chk("abort_m_data", {M_addr, M_write_data}, '0);
      r_acc[0] = 1'b0;
      sav0 = done_cnt[0]; sav1 = done_cnt[1];
      repeat (2) @(negedge ACLK);
      rst_n = 1'b1;
      repeat (8) @(negedge ACLK);
      chk("abort_no_done", {done_cnt[0], done_cnt[1]}, {sav0, sav1});
      chk("abort_idle", busy, 1'b0);
      cmdq0.push_back(mk(1'b0, 32'h104, 32'h0, 4'h0, 0));
      req_run(0);
      chk("post_rst_done", done_cnt[0], sav0 + 1);
      chk("scoreboard_empty", expq.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(env[0].fin && env[1].fin) && t < 60000) begin
      @(posedge ACLK);
      t++;
    end
    chk("env_finish", t < 60000, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
